spi_slave: RTL
==============

# spi_slave

SPI target (slave) endpoint that pairs with the team's `spi_master` on the same four-wire bus. It uses SPI mode 3: SCK idles high, data is shifted on the SCK falling edge and sampled on the rising edge, MSB first, 1–32 bits per frame. The bus pins are oversampled in the `clk_in` domain and frames are converted to/from parallel words for FPGA-side logic. The block sits at the far end of the SPI link, either on-chip for loopback co-simulation or as the peripheral-side controller.

## Interface
Parameters: none (frame width fixed at up to 32 bits).

Ports:
- clk_in  in  1  logic clock; reset nrst, asynchronous, active-low; clock clk_in.
- nrst  in  1  asynchronous active-low reset.
- spi_csn  in  1  chip select from master, active low.
- spi_sck  in  1  SPI clock from master, idles high.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data, registered.
- tx_data  in  32  reply word, right-aligned.
- tx_nbits  in  6  reply length minus 1 (0 means 1 bit; values 32–63 are treated as 31).
- tx_load  in  1  strobe that latches tx_data/tx_nbits; honoured only when not busy.
- rx_data  out  32  last received word, right-aligned.
- rx_nbits  out  6  bits received minus 1 in the last frame; saturates at 31.
- rx_overrun  out  1  last frame carried more than 32 bits.
- rx_valid  out  1  one-cycle pulse: rx_* fields updated.
- busy  out  1  synchronized CSN is low (frame in progress).

## Operation
- Input sync: spi_csn, spi_sck and spi_mosi each pass through a 2-FF synchronizer plus a delay stage for edge detection. Reset values are csn=1, sck=1, mosi=1.
- States:
  - IDLE → ACTIVE on synchronized CSN falling edge.
  - ACTIVE → DONE on synchronized CSN rising edge.
  - DONE → IDLE unconditionally after 1 cycle.
- On entry to ACTIVE:
  - tx_idx is set to the latched tx_nbits.
  - The rx shift register and bit count are cleared.
  - spi_miso holds 1 until the first SCK falling edge.
- SCK falling edge in ACTIVE:
  - spi_miso is set to tx_reg[tx_idx].
  - tx_idx decrements.
  - Once tx_idx has passed 0, spi_miso is driven 0 for the remaining bits.
- SCK rising edge in ACTIVE:
  - rx_shift becomes {rx_shift[30:0], mosi_sync}.
  - bit_cnt increments, saturating at 63.
  - If bit_cnt was already ≥32, the overrun flag is set.
  - Only the most recent 32 bits are retained.
- DONE:
  - If bit_cnt > 0: rx_data = rx_shift, rx_nbits = min(bit_cnt−1, 31), rx_overrun = flag, and rx_valid pulses.
  - If bit_cnt = 0, no pulse and the rx_* fields are unchanged.
  - spi_miso returns to 1.
- tx_load:
  - In IDLE/DONE it captures tx_data/tx_nbits into tx_reg.
  - It is ignored while busy.
  - Without a new load, each frame re-sends the last latched word.
- Simultaneous SCK rising edge and CSN rising edge in the same cycle: the bit is shifted in first, then the frame closes, so it is counted.
- SCK edges while CSN is high are ignored.
- Asynchronous reset mid-frame forces reset values immediately; the aborted frame never produces rx_valid.

## Timing
- Reset values: spi_miso=1, rx_data=0, rx_nbits=0, rx_overrun=0, rx_valid=0, busy=0, tx_reg=0, tx_nbits latch=0.
- SCK falling edge on the pin → new spi_miso value: 3 clk_in cycles (2 sync + 1 output register).
- Constraint: SCK half-period ≥ 5 clk_in cycles, so MISO is stable before the master samples. With the master on the same clk_in, this means DIV_COEF ≥ 4.
- CSN rising edge on the pin → rx_valid pulse: 4 clk_in cycles. rx_valid is high for exactly 1 cycle.
- busy follows the pin CSN level with 2 cycles of latency.
- MOSI is captured through the same sync depth as SCK. The master changes MOSI at the falling edge, so it is stable a half-period before the rising edge.
- tx_load must be issued at least 1 cycle before busy rises to apply to that frame.

## Test plan
- Back-to-back with spi_master (DIV_COEF=4):
  - Stimulus: master sends 0xA5 with nbits=7; slave has tx 0x3C with tx_nbits=7.
  - Required: slave rx_data=0x000000A5, rx_nbits=7, rx_overrun=0, one rx_valid pulse; master miso_data=0x0000003C.
- 32-bit exchange:
  - Stimulus: master sends 0xDEADBEEF with nbits=31; slave tx 0x12345678 with tx_nbits=31.
  - Required: slave rx_data=0xDEADBEEF, rx_nbits=31; master reads 0x12345678.
- 1-bit and short reply:
  - Stimulus 1: master sends 1 bit (nbits=0, value 1).
  - Required: rx_data=0x1, rx_nbits=0.
  - Stimulus 2: master sends 8 bits while slave tx_nbits=3 with tx 0xB.
  - Required: master reads 0xB0 (trailing zeros).
- Bench-driven 40-bit frame of 0xFF00112233:
  - Required: rx_data=0x00112233, rx_nbits=31, rx_overrun=1.
- Protocol corner cases:
  - CSN pulsed low with no SCK edges → no rx_valid.
  - tx_load of 0x55 asserted while busy → the current frame still sends the old word; the next frame sends 0x55.
- nrst asserted after 5 of 8 bits:
  - Required: spi_miso=1 and busy=0 immediately, no rx_valid.
  - A following clean 8-bit frame is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-3 target: oversamples CSN/SCK/MOSI in the clk_in domain and converts
// 1..32-bit MSB-first frames to/from right-aligned parallel words.
module spi_slave (
  input  logic        clk_in,
  input  logic        nrst,
  input  logic        spi_csn,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_nbits,
  input  logic        tx_load,
  output logic [31:0] rx_data,
  output logic [5:0]  rx_nbits,
  output logic        rx_overrun,
  output logic        rx_valid,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic        csn_s1_q, csn_s2_q, csn_d_q;
  logic        sck_s1_q, sck_s2_q, sck_d_q;
  logic        mosi_s1_q, mosi_s2_q;

  logic [1:0]  state_q, state_d;
  logic [31:0] tx_reg_q, tx_reg_d;
  logic [5:0]  tx_nb_q, tx_nb_d;
  logic [4:0]  tx_idx_q, tx_idx_d;
  logic        tx_end_q, tx_end_d;
  logic [31:0] rx_shift_q, rx_shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        ovf_q, ovf_d;
  logic        miso_q, miso_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [5:0]  rx_nbits_q, rx_nbits_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_valid_q, rx_valid_d;

  logic csn_fall, csn_rise, sck_fall, sck_rise;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      csn_s1_q  <= 1'b1;
      csn_s2_q  <= 1'b1;
      csn_d_q   <= 1'b1;
      sck_s1_q  <= 1'b1;
      sck_s2_q  <= 1'b1;
      sck_d_q   <= 1'b1;
      mosi_s1_q <= 1'b1;
      mosi_s2_q <= 1'b1;
    end else begin
      csn_s1_q  <= spi_csn;
      csn_s2_q  <= csn_s1_q;
      csn_d_q   <= csn_s2_q;
      sck_s1_q  <= spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign csn_fall = csn_d_q & ~csn_s2_q;
  assign csn_rise = ~csn_d_q & csn_s2_q;
  assign sck_fall = sck_d_q & ~sck_s2_q;
  assign sck_rise = ~sck_d_q & sck_s2_q;

  always_comb begin
    state_d    = state_q;
    tx_reg_d   = tx_reg_q;
    tx_nb_d    = tx_nb_q;
    tx_idx_d   = tx_idx_q;
    tx_end_d   = tx_end_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    ovf_d      = ovf_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_nbits_d = rx_nbits_q;
    rx_ovr_d   = rx_ovr_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d    = ST_ACTIVE;
          tx_idx_d   = tx_nb_q[5] ? 5'd31 : tx_nb_q[4:0];
          tx_end_d   = 1'b0;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          ovf_d      = 1'b0;
          miso_d     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sck_fall) begin
          if (tx_end_q) begin
            miso_d = 1'b0;
          end else begin
            miso_d = tx_reg_q[tx_idx_q];
            if (tx_idx_q == 5'd0) tx_end_d = 1'b1;
            else                  tx_idx_d = tx_idx_q - 5'd1;
          end
        end
        if (sck_rise) begin
          rx_shift_d = {rx_shift_q[30:0], mosi_s2_q};
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q >= 6'd32) ovf_d = 1'b1;
        end
        // A same-cycle SCK rise is shifted above before the frame closes.
        if (csn_rise) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        miso_d  = 1'b1;
        if (bit_cnt_q != 6'd0) begin
          rx_data_d  = rx_shift_q;
          rx_nbits_d = (bit_cnt_q > 6'd32) ? 6'd31 : bit_cnt_q - 6'd1;
          rx_ovr_d   = ovf_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load && csn_s2_q && (state_q != ST_ACTIVE)) begin
      tx_reg_d = tx_data;
      tx_nb_d  = tx_nbits;
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      tx_reg_q   <= '0;
      tx_nb_q    <= '0;
      tx_idx_q   <= '0;
      tx_end_q   <= 1'b0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      miso_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_nbits_q <= '0;
      rx_ovr_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_reg_q   <= tx_reg_d;
      tx_nb_q    <= tx_nb_d;
      tx_idx_q   <= tx_idx_d;
      tx_end_q   <= tx_end_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ovf_q      <= ovf_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_nbits_q <= rx_nbits_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_miso   = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_nbits   = rx_nbits_q;
  assign rx_overrun = rx_ovr_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = ~csn_s2_q;

endmodule
